// File: rtl/div_unit_r32m.sv
// div_unit_r32m
//   Iterative radix-2 restoring divider for RV32M DIV, DIVU, REM and REMU.
//   It produces one quotient bit per clock. Operands are converted to
//   magnitudes on accept, and the sign is corrected in a final FIX cycle.
//
// Ports
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high; abandons any in-flight operation
//   start  : request strobe, sampled only while idle (including the done cycle)
//   op     : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A, B   : dividend, divisor
//   busy   : high from the cycle after an accepted start until done
//   done   : one-cycle strobe; result valid in the same cycle
//   result : quotient or remainder, held until the next done
//
// Build option
//   DIV_FASTPATH_EN : when defined, divide-by-zero and signed overflow are
//                     detected on accept and skip the iteration phase
//                     (latency 2 instead of dataW+2). Results are identical.
module div_unit_r32m #(
    parameter int dataW = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [dataW-1:0] A,
    input  logic [dataW-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [dataW-1:0] result
);

    localparam int              cntW     = $clog2(dataW + 1);
    localparam logic [cntW-1:0] cnt_init = cntW'(dataW);
    localparam logic [cntW-1:0] cnt_last = cntW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    state_t state, state_nxt;

    // Latched operation context
    logic [dataW-1:0] rem_q;
    logic [dataW-1:0] quo_q;
    logic [dataW-1:0] div_q;
    logic [dataW-1:0] result_q;
    logic [cntW-1:0]  cnt_q;
    logic             sel_rem_q;
    logic             qsign_q;
    logic             rsign_q;
    logic             done_q;

    // Accept-time operand conditioning
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [dataW-1:0] a_mag;
    logic [dataW-1:0] b_mag;
    logic [dataW-1:0] rem_init;
    logic             fast;
    logic             accept;

    // Iteration and fix-up datapath
    logic [dataW:0]   shifted;
    logic [dataW-1:0] rem_diff;
    logic             trial_ok;
    logic [dataW-1:0] q_fix;
    logic [dataW-1:0] r_fix;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & A[dataW-1];
        b_neg     = signed_op & B[dataW-1];
        // Negating the most-negative value yields the same bit pattern,
        // which is the correct magnitude when read as unsigned.
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
`ifdef DIV_FASTPATH_EN
        // Preload the registers so that FIX yields the architectural result
        // without iterating. Divide by zero keeps |A| in the remainder (the
        // quotient is forced to all ones in FIX). Overflow leaves |A| =
        // most-negative in the quotient with a positive quotient sign.
        fast      = (B == '0)
                  | (signed_op & (A == {1'b1, {(dataW-1){1'b0}}}) & (B == '1));
        rem_init  = (B == '0) ? a_mag : '0;
`else
        fast      = 1'b0;
        rem_init  = '0;
`endif
    end

    always_comb begin
        // The trial subtract is effectively dataW+1 bits wide: the compare
        // covers the full shifted value. Only the low dataW bits of the
        // difference are kept because an accepted remainder is always less
        // than the divisor.
        shifted  = {rem_q, quo_q[dataW-1]};
        trial_ok = (shifted >= {1'b0, div_q});
        rem_diff = shifted[dataW-1:0] - div_q;

        // Divide by zero: the datapath produces |A| as the remainder, which
        // becomes A after sign correction. The quotient must be forced to
        // all ones for signed negative dividends as well.
        q_fix    = qsign_q ? -quo_q : quo_q;
        if (div_q == '0) begin
            q_fix = '1;
        end
        r_fix    = rsign_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = fast ? FIX : ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (cnt_q == cnt_last) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            sel_rem_q <= 1'b0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sel_rem_q <= op[1];
                        quo_q     <= a_mag;
                        div_q     <= b_mag;
                        rem_q     <= rem_init;
                        qsign_q   <= a_neg ^ b_neg;
                        rsign_q   <= a_neg;
                        cnt_q     <= cnt_init;
                    end
                end
                ITER: begin
                    quo_q <= {quo_q[dataW-2:0], trial_ok};
                    rem_q <= trial_ok ? rem_diff : shifted[dataW-1:0];
                    cnt_q <= cnt_q - cnt_last;
                end
                FIX: begin
                    result_q <= sel_rem_q ? r_fix : q_fix;
                    done_q   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit_r32m.sv
module tb_div_unit_r32m;

    localparam int W = 32;
    localparam int unsigned LAT = 34;
`ifdef DIV_FASTPATH_EN
    localparam int unsigned SPEC_LAT = 2;
`else
    localparam int unsigned SPEC_LAT = 34;
`endif

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        int unsigned  due;
    } exp_t;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        logic         special;
    } vec_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    div_unit_r32m #(.dataW(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got no summary, want finish");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge: drives start for one cycle and checks acceptance.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int unsigned lat, input bit track);
        exp_t e;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (track) begin
            e.res = exp;
            e.due = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clock);
        start = 1'b0;
        op    = 2'($urandom_range(3));
        A     = $urandom;
        B     = $urandom;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_busy: busy got %b want 1", busy);
        end
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        exp_t e;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_timeout: done got %b want 1 within 100 cycles", name, done);
        end else if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s_unexpected: done got 1 want no pending request", name);
        end else begin
            e = sb.pop_front();
            if (result !== e.res) begin
                miscompares++;
                $display("FAIL %s_result: got %h want %h", name, result, e.res);
            end
            vectors++;
            if (cyc !== e.due) begin
                miscompares++;
                $display("FAIL %s_latency: done at cycle %0d want %0d", name, cyc, e.due);
            end
        end
    endtask

    task automatic watch_idle(input int unsigned n, input logic [W-1:0] exp_res, input string name);
        bit           bad = 0;
        logic         bad_done = 1'b0;
        logic         bad_busy = 1'b0;
        logic [W-1:0] bad_res  = '0;
        repeat (n) begin
            @(negedge clock);
            if (!bad && (done !== 1'b0 || busy !== 1'b0 || result !== exp_res)) begin
                bad      = 1;
                bad_done = done;
                bad_busy = busy;
                bad_res  = result;
            end
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s_idle: done=%b busy=%b result=%h want done=0 busy=0 result=%h",
                     name, bad_done, bad_busy, bad_res, exp_res);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = OP_DIV;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clock);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        vectors++;
        if (result !== '0) begin
            miscompares++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_arith();
        vec_t tbl [0:18];
        tbl = '{
            '{OP_DIV,  32'd18,         32'd4,          32'd4,          1'b0},
            '{OP_REM,  32'd18,         32'd4,          32'd2,          1'b0},
            '{OP_DIV,  32'd18,         32'hFFFF_FFFC,  32'hFFFF_FFFC,  1'b0},
            '{OP_REM,  32'd18,         32'hFFFF_FFFC,  32'd2,          1'b0},
            '{OP_REM,  32'hFFFF_FFEE,  32'd4,          32'hFFFF_FFFE,  1'b0},
            '{OP_REM,  32'hFFFF_FFEE,  32'hFFFF_FFFC,  32'hFFFF_FFFE,  1'b0},
            '{OP_DIV,  32'hFFFF_FFEE,  32'hFFFF_FFFC,  32'd4,          1'b0},
            '{OP_DIVU, 32'hFFFF_FFFE,  32'd3,          32'h5555_5554,  1'b0},
            '{OP_REMU, 32'hFFFF_FFFE,  32'd3,          32'd2,          1'b0},
            '{OP_DIV,  32'hFFFF_FFFE,  32'd3,          32'd0,          1'b0},
            '{OP_REM,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFE,  1'b0},
            '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0},
            '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0},
            '{OP_DIVU, 32'd7,          32'd0,          32'hFFFF_FFFF,  1'b1},
            '{OP_REMU, 32'd7,          32'd0,          32'd7,          1'b1},
            '{OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1'b1},
            '{OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1},
            '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1},
            '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1}
        };
        for (int i = 0; i < 19; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp,
                  tbl[i].special ? SPEC_LAT : LAT, 1'b1);
            wait_done($sformatf("arith%0d", i));
            @(negedge clock);
        end
    endtask

    task automatic test_busy_start();
        issue(OP_DIV, 32'd100, 32'd7, 32'd14, LAT, 1'b1);
        repeat (12) @(negedge clock);
        start = 1'b1;
        op    = OP_DIVU;
        A     = 32'd50;
        B     = 32'd5;
        @(negedge clock);
        start = 1'b0;
        wait_done("busy_start");
    endtask

    task automatic test_back_to_back();
        // Still at the negedge of the done cycle from the previous task.
        issue(OP_DIV, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, LAT, 1'b1);
        wait_done("back_to_back");
        @(negedge clock);
        watch_idle(40, 32'hFFFF_FEB3, "after_b2b");
    endtask

    task automatic test_reset_mid();
        issue(OP_DIV, 32'd100, 32'd7, 32'd14, LAT, 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_busy: got %b want 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_done: got %b want 0", done);
        end
        vectors++;
        if (result !== '0) begin
            miscompares++;
            $display("FAIL midreset_result: got %h want 0", result);
        end
        watch_idle(40, '0, "after_reset");
        issue(OP_REMU, 32'd100, 32'd7, 32'd2, LAT, 1'b1);
        wait_done("post_reset");
    endtask

    initial begin
        test_reset();
        test_arith();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        @(negedge clock);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_unit_r32m.md
Name: div_unit_r32m

Overview:
- Iterative multi-cycle divider that services RV32M divide/remainder requests (DIV, DIVU, REM, REMU).
- Replaces the single-cycle divide path of the combinational ALU.
- Sits beside the ALU in the execute stage. The issuing pipeline drives operands and a start pulse, then waits for a one-cycle done strobe.
- Radix-2 restoring algorithm: one quotient bit per clock.

Parameters:
- dataW, 32: operand and result width in bits; must be even and at least 4.

Ports:
- clock, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request strobe; sampled only in IDLE.
- op, input, 2: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
- A, input, dataW: dividend.
- B, input, dataW: divisor.
- busy, output, 1: high from the cycle after an accepted start until done has been asserted.
- done, output, 1: one-cycle strobe; result is valid in the same cycle.
- result, output, dataW: quotient or remainder; held stable until the next done.

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0; internal registers cleared.
  - Reset wins over every other input, including mid-operation.
  - An in-flight operation is abandoned with no done.
- States: IDLE, ITER, FIX.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Latch the magnitudes |A| and |B|. Magnitudes are taken only for signed ops with a negative operand; otherwise the raw value is used.
  - Latch the result signs: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
  - Clear the partial remainder; load the iteration counter with dataW.
  - Go to ITER; busy=1.
- ITER, each edge:
  - Shift {rem, quo} left by 1.
  - Trial subtract: rem - divisor, computed dataW+1 bits wide.
  - If non-negative: store the difference and set the quotient LSB to 1. Otherwise restore and set it to 0.
  - Decrement the counter; after the dataW-th iteration go to FIX.
- FIX, one edge:
  - Apply sign correction (two's-complement negate where the latched sign is 1).
  - Select quotient (op[1]=0) or remainder (op[1]=1) into result.
  - done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: done is high in the cycle following edge E0+dataW+1, i.e. 34 cycles after the start cycle for dataW=32.
- start while busy: ignored. Operands and op may change freely while busy without affecting the result.
- start in the same cycle done is high: accepted (state is IDLE-equivalent). Back-to-back issue is supported with zero bubble.
- Divide by zero (B=0), RISC-V semantics:
  - quotient = all ones (DIV and DIVU).
  - remainder = A.
- Signed overflow (A = most-negative, B = -1, DIV/REM):
  - quotient = most-negative value.
  - remainder = 0.
- Both special cases must fall out of the datapath or be forced in FIX. They never raise an exception.
- Unsigned ops never negate.
- The magnitude of the most-negative value is computed dataW bits wide; it is correct when treated as unsigned.

Optional Feature:
- Macro: DIV_FASTPATH_EN.
- Defined:
  - Divide-by-zero and signed-overflow cases are detected at E0.
  - The block skips ITER and goes directly to FIX.
  - done appears in the cycle after the start cycle + 1 (latency 2).
  - Results are identical to the non-fast-path values.
- Not defined: all operations, special cases included, take the full dataW+2 latency. No detection logic is synthesised.

Test Plan:
- A=18, B=4, op=DIV -> result=4 with done exactly 34 cycles after start; op=REM -> 2.
- A=18, B=-4: DIV -> 0xFFFFFFFC (-4), REM -> 2. A=-18, B=4: REM -> 0xFFFFFFFE (-2). A=-18, B=-4: REM -> -2, DIV -> 4.
- A=0xFFFFFFFE, B=3, op=DIVU -> 0x55555554; REMU -> 2. op=DIV -> 0 and REM -> -2.
- A=7, B=0:
  - DIVU -> 0xFFFFFFFF; REMU -> 7.
  - A=0x80000000, B=0xFFFFFFFF, DIV -> 0x80000000, REM -> 0.
  - Check latency 2 with DIV_FASTPATH_EN and 34 without.
- Start DIV 100/7, then pulse start with different operands mid-ITER -> ignored, result=14. Issue a second start in the done cycle -> accepted, with correct second result 34 cycles later.
- Assert reset at iteration 10 -> the next cycle shows busy=0, done=0, result=0, and no done follows. A fresh start then completes normally.
